// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu micro-program sequencer: opcode capture, LUT dispatch,
// uPC stepping, CB prefix hop and flow-field strobe decode.
module dzcpu_uop_sequencer #(
  parameter int UPC_W        = 8,
  parameter int MAX_FLOW_LEN = 32
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [7:0]       iMemData,
  input  logic             iMemReady,
  output logic [7:0]       oMop,
  input  logic [UPC_W-1:0] iLutIdx,
  input  logic [UPC_W-1:0] iCbLutIdx,
  output logic [UPC_W-1:0] oUopAddr,
  input  logic [2:0]       iUopFlow,
  input  logic             iJcb,
  input  logic             iZFlag,
  input  logic             iStall,
  output logic             oUopValid,
  output logic             oPcInc,
  output logic             oFlagUpdate,
  output logic             oInstrDone,
  output logic             oUcodeErr
);

  localparam int CNT_W = $clog2(MAX_FLOW_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FLOW_LEN - 1);

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXEC,
    CB_DECODE
  } state_e;

  state_e           state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic [7:0]       mop_q, mop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic flow_inc, flow_fu, flow_end;
  logic run, hold, fire;

  always_comb begin
    flow_inc = 1'b0;
    flow_fu  = 1'b0;
    flow_end = 1'b0;
    unique case (iUopFlow)
      3'd0: ;
      3'd1: flow_inc = 1'b1;
      3'd2: flow_end = 1'b1;
      3'd3: begin flow_inc = 1'b1; flow_end = 1'b1; end
      3'd4: begin flow_fu = 1'b1; flow_end = 1'b1; end
      3'd5: begin
        flow_inc = 1'b1;
        flow_fu  = 1'b1;
        flow_end = 1'b1;
      end
      3'd6: begin flow_inc = 1'b1; flow_end = iZFlag; end
      3'd7: begin flow_inc = 1'b1; flow_end = ~iZFlag; end
    endcase
  end

  // A CB hop needs the prefix operand byte; without it the uop waits.
  assign run  = (state_q == EXEC) && !iStall;
  assign hold = run && !flow_end && iJcb && !iMemReady;
  assign fire = run && !hold;

  assign oUopValid   = fire;
  assign oPcInc      = fire && flow_inc;
  assign oFlagUpdate = fire && flow_fu;
  assign oInstrDone  = fire && flow_end;
  assign oUopAddr    = upc_q;
  assign oMop        = mop_q;
  assign oUcodeErr   = err_q;

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    mop_d   = mop_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      FETCH: begin
        if (iMemReady) begin
          mop_d   = iMemData;
          state_d = DECODE;
        end
      end
      DECODE: begin
        upc_d   = iLutIdx;
        cnt_d   = '0;
        state_d = EXEC;
      end
      EXEC: begin
        if (fire) begin
          if (flow_end) begin
            state_d = FETCH;
          end else if (upc_q == '1 || cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = FETCH;
          end else begin
            upc_d = upc_q + UPC_W'(1);
            cnt_d = cnt_q + CNT_W'(1);
            if (iJcb) begin
              mop_d   = iMemData;
              state_d = CB_DECODE;
            end
          end
        end
      end
      CB_DECODE: begin
        upc_d   = iCbLutIdx;
        state_d = EXEC;
      end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= FETCH;
      upc_q   <= '0;
      mop_q   <= 8'h00;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      mop_q   <= mop_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Bench for dzcpu_uop_sequencer: small LUT/ROM model, per-cycle
// vector table plus watchdog, reset and uPC-wrap sequences.
module tb_dzcpu_uop_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] mem_data;
  logic       mem_rdy;
  logic [7:0] mop;
  logic [7:0] lut_idx;
  logic [7:0] cb_idx;
  logic [7:0] uaddr;
  logic [2:0] flow;
  logic       jcb;
  logic       zf;
  logic       stall;
  logic       uvalid;
  logic       pcinc;
  logic       fupd;
  logic       done;
  logic       uerr;

  logic [2:0] rom_flow [256];
  logic       rom_jcb  [256];
  logic [7:0] lut      [256];
  logic [7:0] cblut    [256];

  int checks = 0;
  int errors = 0;

  dzcpu_uop_sequencer #(.UPC_W(8), .MAX_FLOW_LEN(32)) dut (
    .iClock     (clk),
    .iReset     (rst),
    .iMemData   (mem_data),
    .iMemReady  (mem_rdy),
    .oMop       (mop),
    .iLutIdx    (lut_idx),
    .iCbLutIdx  (cb_idx),
    .oUopAddr   (uaddr),
    .iUopFlow   (flow),
    .iJcb       (jcb),
    .iZFlag     (zf),
    .iStall     (stall),
    .oUopValid  (uvalid),
    .oPcInc     (pcinc),
    .oFlagUpdate(fupd),
    .oInstrDone (done),
    .oUcodeErr  (uerr)
  );

  assign lut_idx = lut[mop];
  assign cb_idx  = cblut[mop];
  assign flow    = rom_flow[uaddr];
  assign jcb     = rom_jcb[uaddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       stl;
    logic       z;
    logic [7:0] addr;
    logic [7:0] mop;
    logic       v;
    logic       i;
    logic       f;
    logic       d;
    logic       e;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [7:0] dt,
                     input logic s, input logic z,
                     input logic [7:0] a, input logic [7:0] m,
                     input logic v, input logic i, input logic f,
                     input logic d, input logic e);
    vec_t t;
    t.rdy = r; t.data = dt; t.stl = s; t.z = z;
    t.addr = a; t.mop = m;
    t.v = v; t.i = i; t.f = f; t.d = d; t.e = e;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic rdy_i,
                      input logic [7:0] dt, input logic s,
                      input logic z);
    @(negedge clk);
    rst = r; mem_rdy = rdy_i; mem_data = dt; stall = s; zf = z;
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {11'd0, uaddr, mop, uvalid, pcinc, fupd, done, uerr};
  endfunction

  initial begin
    for (int k = 0; k < 256; k++) begin
      rom_flow[k] = 3'd0;
      rom_jcb[k]  = 1'b0;
      lut[k]      = 8'd0;
      cblut[k]    = 8'd0;
    end
    rom_flow[0] = 3'd2;
    lut[8'h21] = 8'd5;
    rom_flow[5] = 3'd1; rom_flow[6] = 3'd1;
    rom_flow[7] = 3'd0; rom_flow[8] = 3'd3;
    lut[8'h20] = 8'd17;
    rom_flow[19] = 3'd6; rom_flow[22] = 3'd2;
    lut[8'hCB] = 8'd15;
    rom_flow[15] = 3'd1; rom_jcb[15] = 1'b1;
    cblut[8'h7C] = 8'd16;
    rom_flow[16] = 3'd4;
    lut[8'h10] = 8'd100;
    lut[8'h35] = 8'd53;
    lut[8'h55] = 8'd254;

    // rdy data stl z | addr mop v i f d e
    add(1, 8'h21, 0, 0,  0, 8'h00, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 8'h21, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0,  5, 8'h21, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0,  6, 8'h21, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0,  7, 8'h21, 1, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0,  8, 8'h21, 1, 1, 0, 1, 0);
    add(1, 8'h21, 0, 0,  8, 8'h21, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0,  8, 8'h21, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0,  5, 8'h21, 1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0,  6, 8'h21, 0, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0,  6, 8'h21, 0, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0,  6, 8'h21, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0,  6, 8'h21, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0,  7, 8'h21, 1, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0,  8, 8'h21, 1, 1, 0, 1, 0);
    add(1, 8'h20, 0, 0,  8, 8'h21, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0,  8, 8'h20, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 17, 8'h20, 1, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 18, 8'h20, 1, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 19, 8'h20, 1, 1, 0, 1, 0);
    add(1, 8'h20, 0, 0, 19, 8'h20, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 19, 8'h20, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 17, 8'h20, 1, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 18, 8'h20, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 1, 19, 8'h20, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 19, 8'h20, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 20, 8'h20, 1, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 21, 8'h20, 1, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 22, 8'h20, 1, 0, 0, 1, 0);
    add(1, 8'hCB, 0, 0, 22, 8'h20, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 22, 8'hCB, 0, 0, 0, 0, 0);
    add(0, 8'h7C, 0, 0, 15, 8'hCB, 0, 0, 0, 0, 0);
    add(1, 8'h7C, 0, 0, 15, 8'hCB, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 16, 8'h7C, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 16, 8'h7C, 1, 0, 1, 1, 0);
    add(1, 8'h10, 0, 0, 16, 8'h7C, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 16, 8'h10, 0, 0, 0, 0, 0);

    rst = 1'b1; mem_rdy = 1'b0; mem_data = 8'h00;
    stall = 1'b0; zf = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[n]) begin
      step(0, vecs[n].rdy, vecs[n].data, vecs[n].stl, vecs[n].z);
      chk($sformatf("vec%0d", n), outs(),
          {11'd0, vecs[n].addr, vecs[n].mop, vecs[n].v,
           vecs[n].i, vecs[n].f, vecs[n].d, vecs[n].e});
    end

    // Watchdog: 32 flow-0 uops from 100, then abort without done
    for (int k = 0; k < 32; k++) begin
      step(0, 0, 8'h00, 0, 0);
      chk($sformatf("wdog_uop%0d", k + 1),
          {24'd0, uaddr, uvalid, done, uerr},
          {24'd0, 8'(100 + k), 1'b1, 1'b0, 1'b0});
    end
    step(0, 0, 8'h00, 0, 0);
    chk("wdog_abort", {29'd0, uvalid, done, uerr}, 32'b001);
    step(0, 1, 8'h35, 0, 0);
    chk("err_sticky_fetch", {31'd0, uerr}, 32'd1);
    step(0, 0, 8'h00, 0, 0);
    chk("err_sticky_decode", {24'd0, mop}, 32'h35);
    step(1, 0, 8'h00, 0, 0);
    chk("exec_53", {23'd0, uaddr, uvalid, uerr}, {23'd0, 8'd53, 2'b11});
    step(0, 0, 8'h00, 0, 0);
    chk("after_reset", outs(), 32'd0);

    // uPC wrap: flow starting at 254 runs off the end of the ROM
    step(0, 1, 8'h55, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("wrap_254", {23'd0, uaddr, uvalid, uerr}, {23'd0, 8'd254, 2'b10});
    step(0, 0, 8'h00, 0, 0);
    chk("wrap_255", {23'd0, uaddr, uvalid, uerr}, {23'd0, 8'd255, 2'b10});
    step(0, 0, 8'h00, 0, 0);
    chk("wrap_abort", {29'd0, uvalid, done, uerr}, 32'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
